// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared constants, state codes and helpers for the PC fetch controller
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] WORD_ZERO   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    PFC_IDLE  = 2'd0,
    PFC_FETCH = 2'd1,
    PFC_DRAIN = 2'd2,
    PFC_HALT  = 2'd3
  } pfc_state_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts consecutive unanswered fetch cycles, flags a hung imem
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int             W    = $clog2(TIMEOUT);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT - 1);

  logic [W-1:0] wait_cnt;

  // Expiry always halts the controller, so the count never needs to wrap past LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != LAST)) begin
      wait_cnt <= wait_cnt + W'(1);
    end
  end

  assign expired = inc && (wait_cnt == LAST);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC write / imem request sequencer with stall, redirect, drain and halt
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_write,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        fetch_err
);

  pfc_state_t  state, state_nxt;
  logic [31:0] pend_target, pend_nxt;
  logic        err_nxt;
  logic        active, expired, bad_target;

  assign active     = (state == PFC_FETCH) || (state == PFC_DRAIN);
  assign bad_target = redirect_valid && !word_aligned(redirect_target);

  fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .inc     (active && !imem_ready),
    .clr     (active && imem_ready),
    .expired (expired)
  );

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend_target;
    err_nxt    = fetch_err;
    pc_next    = pc_cur + INSTR_BYTES;
    pc_write   = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc_cur;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    if (!rst) begin
      // Outputs stay quiet while reset is held, even though the state already reads IDLE.
      pc_next = RESET_VECTOR;
    end else begin
      case (state)
        PFC_IDLE: begin
          pc_write  = 1'b1;
          pc_next   = RESET_VECTOR;
          state_nxt = PFC_FETCH;
        end
        PFC_FETCH, PFC_DRAIN: begin
          imem_req   = 1'b1;
          ifid_flush = redirect_valid;
          if (expired || bad_target) begin
            state_nxt = PFC_HALT;
            err_nxt   = 1'b1;
          end else if (redirect_valid) begin
            pend_nxt = redirect_target;
            if (imem_ready) begin
              pc_write  = 1'b1;
              pc_next   = redirect_target;
              state_nxt = PFC_FETCH;
            end else begin
              state_nxt = PFC_DRAIN;
            end
          end else if (imem_ready) begin
            if (state == PFC_DRAIN) begin
              pc_write  = 1'b1;
              pc_next   = pend_target;
              state_nxt = PFC_FETCH;
            end else if (!stall) begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PFC_IDLE;
      pend_target <= WORD_ZERO;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_target <= pend_nxt;
      fetch_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed and randomized checks of pc_fetch_ctrl against a queue-based model
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int          TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        ifid_write;
  logic        ifid_flush;
  logic        fetch_err;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_ctrl #(.RESET_VECTOR(RV), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .pc_write        (pc_write),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  // PC register of the fetch stage, with a bench-side preload port.
  always @(posedge clk or negedge rst) begin
    if (!rst)          pc_cur <= RV;
    else if (pc_load)  pc_cur <= pc_load_val;
    else if (pc_write) pc_cur <= pc_next;
  end

  // Reference model: booted/halted flags, a queue holding the redirect awaiting drain,
  // and a plain count of consecutive unanswered fetch cycles.
  logic [31:0] m_pc;
  bit          m_booted, m_halted, m_err;
  int          m_wait;
  logic [31:0] pend_q[$];

  logic [31:0] obs_addr, obs_next;
  logic        obs_req, obs_ifw, obs_fl, obs_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_booted = 0; m_halted = 0; m_err = 0; m_wait = 0;
    pend_q.delete();
  endtask

  task automatic step(input bit st, input bit rv, input logic [31:0] rt, input bit rdy,
                      input bit ld = 1'b0, input logic [31:0] ldv = 32'h0);
    logic [31:0] e_next;
    bit e_req, e_write, e_ifw, e_fl;
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_target = rt; imem_ready = rdy;
    pc_load = ld; pc_load_val = ldv;
    #1;
    check_val("pc_cur", pc_cur, m_pc);
    check_val("fetch_err", fetch_err, m_err);
    e_req = 0; e_write = 0; e_next = 0; e_ifw = 0; e_fl = 0;
    if (!m_booted) begin
      e_write = 1; e_next = RV; m_booted = 1;
    end else if (!m_halted) begin
      e_req = 1; e_fl = rv;
      if ((!rdy && m_wait + 1 == TIMEOUT) || (rv && (rt % 4 != 0))) begin
        m_halted = 1; m_err = 1;
      end else if (rv) begin
        pend_q.delete();
        if (rdy) begin e_write = 1; e_next = rt; end
        else pend_q.push_back(rt);
      end else if (rdy && pend_q.size() > 0) begin
        e_write = 1; e_next = pend_q.pop_front();
      end else if (rdy && !st) begin
        e_write = 1; e_next = m_pc + 32'd4; e_ifw = 1;
      end
      m_wait = rdy ? 0 : m_wait + 1;
    end
    check_val("imem_req", imem_req, e_req);
    if (e_req) check_val("imem_addr", imem_addr, m_pc);
    check_val("pc_write", pc_write, e_write);
    if (e_write) check_val("pc_next", pc_next, e_next);
    check_val("ifid_write", ifid_write, e_ifw);
    check_val("ifid_flush", ifid_flush, e_fl);
    obs_addr = imem_addr; obs_next = pc_next; obs_req = imem_req;
    obs_ifw = ifid_write; obs_fl = ifid_flush; obs_err = fetch_err;
    if (ld) m_pc = ldv;
    else if (e_write) m_pc = e_next;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; stall = 0; redirect_valid = 0; imem_ready = 0; pc_load = 0;
    #1;
    check_val("rst_pc_write", pc_write, 0);
    check_val("rst_imem_req", imem_req, 0);
    check_val("rst_ifid_write", ifid_write, 0);
    check_val("rst_ifid_flush", ifid_flush, 0);
    check_val("rst_fetch_err", fetch_err, 0);
    check_val("rst_pc_next", pc_next, RV);
    check_val("rst_pc_cur", pc_cur, RV);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  initial begin
    int slow;
    bit st, rv, rdy, ld;
    logic [31:0] rt;

    // Straight-line fetch, then a two-cycle stall at 8, then a redirect with ready.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1);
      check_val("seq_addr", obs_addr, 32'(4 * i));
      check_val("seq_ifw", obs_ifw, 1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1);
      check_val("stall_addr", obs_addr, 32'd8);
      check_val("stall_ifw", obs_ifw, 0);
    end
    step(0, 0, 0, 1);
    check_val("resume_addr", obs_addr, 32'd8);
    step(0, 1, 32'h100, 1);
    check_val("redir_addr", obs_addr, 32'd12);
    check_val("redir_flush", obs_fl, 1);
    step(0, 0, 0, 1);
    check_val("redir_next_addr", obs_addr, 32'h100);

    // Redirect during a slow fetch, then a second redirect overriding the pending one.
    do_reset();
    step(0, 0, 0, 1);
    step(0, 1, 32'h200, 0);
    step(0, 0, 0, 0);
    check_val("drain_hold_addr", obs_addr, 32'd0);
    step(0, 0, 0, 1);
    check_val("drain_discard_ifw", obs_ifw, 0);
    step(0, 0, 0, 1);
    check_val("drain_next_addr", obs_addr, 32'h200);
    step(0, 1, 32'h200, 0);
    step(1, 1, 32'h300, 0);
    check_val("drain_reflush", obs_fl, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_val("drain_override_addr", obs_addr, 32'h300);

    // Reset while draining drops the pending target.
    step(0, 1, 32'h400, 0);
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_val("rst_drain_addr", obs_addr, RV);

    // Misaligned redirect halts fetch until reset.
    step(0, 1, 32'h102, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check_val("halt_err", obs_err, 1);
      check_val("halt_req", obs_req, 0);
    end
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_val("post_halt_err", obs_err, 0);
    check_val("post_halt_addr", obs_addr, RV);

    // Hung imem: error only once TIMEOUT unanswered cycles have elapsed.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0);
    check_val("timeout_not_early", obs_err, 0);
    step(0, 0, 0, 1);
    check_val("timeout_err", obs_err, 1);

    // PC wraps from the top of the address space to zero.
    do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    check_val("wrap_addr", obs_addr, 32'hFFFF_FFFC);
    check_val("wrap_next", obs_next, 32'h0);
    step(0, 0, 0, 1);
    check_val("wrap_after", obs_addr, 32'h0);

    // Randomized traffic against the model.
    slow = 0;
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && ($urandom % 6 == 0)) || ($urandom % 400 == 0)) begin
        do_reset();
        slow = 0;
      end
      if ($urandom % 150 == 0) slow = $urandom_range(4, 20);
      st  = ($urandom % 5 == 0);
      rv  = ($urandom % 8 == 0);
      rt  = $urandom & 32'hFFFF_FFFC;
      if ($urandom % 50 == 0) rt[1:0] = 2'($urandom_range(1, 3));
      rdy = (slow > 0) ? 1'b0 : ($urandom % 4 != 0);
      if (slow > 0) slow--;
      ld  = ($urandom % 120 == 0);
      step(st, rv, rt, rdy, ld, 32'hFFFF_FFF0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
